// File: rtl/fm_modulator.sv
// fm_modulator: FM baseband modulator.
// Each accepted audio sample sets a phase increment, and the block then emits
// INTERP I/Q samples while a phase accumulator advances by that increment.
// I/Q come from a constant quarter-wave table that is built at elaboration.
// Optional feature: define FM_MOD_PREEMPH_EN to pre-emphasise the audio before
// the increment is computed.
module fm_modulator #(
    parameter int DATA_WIDTH    = 32,
    parameter int BITS          = 10,
    parameter int INTERP        = 8,
    parameter int PHASE_BITS    = 16,
    parameter int LUT_ADDR_BITS = 8,
    parameter int MOD_GAIN      = 14080,
    parameter int PREEMPH_K     = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_audio,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_i,
    output logic [DATA_WIDTH-1:0] out_q,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int QN    = 1 << (LUT_ADDR_BITS - 2);   // entries per quarter turn
    localparam int IDX_W = LUT_ADDR_BITS - 1;          // indexes 0..QN inclusive
    localparam int MAG_W = BITS + 1;                   // holds 0..2^BITS
    localparam int CNT_W = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam longint PI_Q30 = 64'sd3373259426;       // pi in Q30

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // round(sin(2*pi*k/2^LUT_ADDR_BITS) * 2^BITS) for the first quarter turn.
    // Taylor series in Q30; the truncation error stays far below half an LSB.
    function automatic longint quarter_sin(input int k);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (2 * PI_Q30 * longint'(k)) >>> LUT_ADDR_BITS;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return ((acc <<< BITS) + (64'sd1 <<< 29)) >>> 30;
    endfunction

    // Quarter-wave magnitude table; entry QN is exactly 2^BITS, so cos(0) is +1.0.
    logic [MAG_W-1:0] qtab [0:QN];

    generate
        for (genvar gi = 0; gi <= QN; gi++) begin : g_qtab
            assign qtab[gi] = MAG_W'(quarter_sin(gi));
        end
    endgenerate

    state_t                  state_q;
    logic [PHASE_BITS-1:0]   phase_q;
    logic [PHASE_BITS-1:0]   inc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   cos_q;
    logic [DATA_WIDTH-1:0]   sin_q;
    logic                    in_ready_q;
    logic                    out_valid_q;

    logic [PHASE_BITS-1:0]    phase_adv_d;
    logic [PHASE_BITS-1:0]    inc_d;
    logic [DATA_WIDTH-1:0]    audio_src_d;
    logic [LUT_ADDR_BITS-1:0] lut_addr_d;
    logic [IDX_W-1:0]         idx_fwd_d;
    logic [IDX_W-1:0]         idx_rev_d;
    logic [DATA_WIDTH-1:0]    mag_fwd_d;
    logic [DATA_WIDTH-1:0]    mag_rev_d;
    logic [DATA_WIDTH-1:0]    cos_d;
    logic [DATA_WIDTH-1:0]    sin_d;

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_i       = cos_q;
    assign out_q       = sin_q;
    assign phase_adv_d = phase_q + inc_q;

`ifdef FM_MOD_PREEMPH_EN
    logic [DATA_WIDTH-1:0] x_prev_q;

    // Pre-emphasis: boost the sample by the scaled difference to the previous one.
    always_comb begin
        audio_src_d = DATA_WIDTH'(longint'($signed(in_audio))
                      + (((longint'($signed(in_audio)) - longint'($signed(x_prev_q)))
                          * longint'(PREEMPH_K)) >>> BITS));
    end
`else
    assign audio_src_d = in_audio;
`endif

    // Phase increment: audio scaled by the modulation gain, wrapped to one turn.
    always_comb begin
        inc_d = PHASE_BITS'((longint'($signed(audio_src_d)) * longint'(MOD_GAIN)) >>> BITS);
    end

    // Table lookup for the phase about to be presented: the current phase on
    // acceptance, the advanced phase while emitting.
    always_comb begin
        lut_addr_d = (state_q == IDLE) ? phase_q[PHASE_BITS-1 -: LUT_ADDR_BITS]
                                       : phase_adv_d[PHASE_BITS-1 -: LUT_ADDR_BITS];
        idx_fwd_d  = {1'b0, lut_addr_d[LUT_ADDR_BITS-3:0]};
        idx_rev_d  = IDX_W'(QN) - idx_fwd_d;
        mag_fwd_d  = DATA_WIDTH'(qtab[idx_fwd_d]);
        mag_rev_d  = DATA_WIDTH'(qtab[idx_rev_d]);
        sin_d      = mag_fwd_d;
        cos_d      = mag_rev_d;
        case (lut_addr_d[LUT_ADDR_BITS-1 -: 2])
            2'd0: begin sin_d =  mag_fwd_d; cos_d =  mag_rev_d; end
            2'd1: begin sin_d =  mag_rev_d; cos_d = -mag_fwd_d; end
            2'd2: begin sin_d = -mag_fwd_d; cos_d = -mag_rev_d; end
            default: begin sin_d = -mag_rev_d; cos_d =  mag_fwd_d; end
        endcase
    end

    // Control FSM with registered handshake flags and registered I/Q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            inc_q       <= '0;
            cnt_q       <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef FM_MOD_PREEMPH_EN
            x_prev_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        inc_q       <= inc_d;
                        cnt_q       <= '0;
                        cos_q       <= cos_d;
                        sin_q       <= sin_d;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= EMIT;
`ifdef FM_MOD_PREEMPH_EN
                        x_prev_q    <= in_audio;
`endif
                    end
                end
                default: begin
                    // A stalled consumer freezes phase, count and I/Q.
                    if (out_ready) begin
                        phase_q <= phase_adv_d;
                        cnt_q   <= cnt_q + 1'b1;
                        cos_q   <= cos_d;
                        sin_q   <= sin_d;
                        if (cnt_q == CNT_W'(INTERP - 1)) begin
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/fm_modulator.md
FM_MODULATOR -- requirements
Module: fm_modulator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the signed audio and I/Q sample width.
REQ-002 The block SHALL have parameter BITS, default 10, giving the fixed-point fraction bits (1.0 = 1024).
REQ-003 The block SHALL have parameter INTERP, default 8, giving the output samples emitted per audio sample.
REQ-004 The block SHALL have parameter PHASE_BITS, default 16, giving the phase accumulator width (2^PHASE_BITS = one full turn).
REQ-005 The block SHALL have parameter LUT_ADDR_BITS, default 8, giving the log2 of the sin/cos table depth.
REQ-006 The block SHALL have parameter MOD_GAIN, default 14080, giving the phase increment per 1.0 of audio (2^16 * 55000 / 256000).
REQ-007 The block SHALL have parameter PREEMPH_K, default 1024, giving the pre-emphasis coefficient in BITS fixed point.
REQ-008 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-009 The block SHALL have port reset, input, 1 bit: the asynchronous, active-high reset.
REQ-010 The block SHALL have port in_audio, input, DATA_WIDTH bits: the signed quantized audio sample.
REQ-011 The block SHALL have port in_valid, input, 1 bit: asserted when in_audio is valid.
REQ-012 The block SHALL have port in_ready, output, 1 bit: asserted when the block can accept a sample.
REQ-013 The block SHALL have port out_i, output, DATA_WIDTH bits: the signed quantized cosine of the phase.
REQ-014 The block SHALL have port out_q, output, DATA_WIDTH bits: the signed quantized sine of the phase.
REQ-015 The block SHALL have port out_valid, output, 1 bit: asserted when out_i and out_q are valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit: asserted when the consumer accepts the sample.

Function
REQ-017 The block SHALL implement FSM states IDLE and EMIT.
- IDLE: in_ready=1, out_valid=0.
- EMIT: in_ready=0, out_valid=1.
REQ-018 In IDLE, in_valid=1 SHALL accept the sample, latch inc, clear the counter cnt to 0 and enter EMIT on the same edge.
- Formula: inc = low PHASE_BITS of ((signed 64-bit in_audio * MOD_GAIN) >>> BITS).
REQ-019 out_i and out_q SHALL be registered.
- Values: round(cos/sin(2*pi*phase[PHASE_BITS-1 -: LUT_ADDR_BITS] / 2^LUT_ADDR_BITS) * 2^BITS).
- The first sample of a group SHALL appear with out_valid in the cycle after acceptance, using the current phase.
REQ-020 In EMIT with out_ready=1, the block SHALL:
- set phase += inc modulo 2^PHASE_BITS;
- increment cnt;
- register I/Q for the new phase.
REQ-021 When cnt==INTERP-1 is accepted, the block SHALL return to IDLE with phase retained; exactly INTERP outputs SHALL be produced per audio sample.
REQ-022 While out_valid=1 and out_ready=0, out_i, out_q, phase and cnt SHALL hold unchanged.
REQ-023 Phase SHALL wrap silently in both directions; negative inc SHALL rotate clockwise.
REQ-024 The LUT SHALL be a constant quarter-wave or full table; cos(0) SHALL equal +1024 exactly, without saturation.
REQ-025 in_valid SHALL be ignored in EMIT; the upstream block holds its sample until in_ready.

Reset
REQ-026 Reset assertion SHALL immediately set:
- state=IDLE, phase=0, inc=0, cnt=0;
- out_valid=0, in_ready=1, out_i=0, out_q=0;
- pre-emphasis history x_prev=0.
REQ-027 Reset mid-group SHALL abandon the remaining outputs; the next accepted sample SHALL start at phase 0.

Configuration
REQ-028 With macro FM_MOD_PREEMPH_EN defined, the accepted audio SHALL be replaced by pre-emphasised audio before computing inc.
- Formula: e = x + (((x - x_prev) * PREEMPH_K) >>> BITS), computed in 64-bit and truncated to DATA_WIDTH.
- x_prev SHALL update to x on every accepted sample.
REQ-029 Without FM_MOD_PREEMPH_EN, in_audio SHALL be used directly, and no x_prev register SHALL exist.

Verification
REQ-030 The bench SHALL cover: in_audio=0 -> 8 outputs (1024,0); in_ready high again after the 8th.
REQ-031 The bench SHALL cover: MOD_GAIN=1024, in_audio=16384 -> (1024,0),(0,1024),(-1024,0),(0,-1024), repeated twice.
REQ-032 The bench SHALL cover: MOD_GAIN=1024, in_audio=-16384 -> (1024,0),(0,-1024),(-1024,0),(0,1024), repeated twice.
REQ-033 The bench SHALL cover: out_ready low for 5 cycles mid-group -> out_valid, out_i and out_q stable, and the group still totals 8 samples.
REQ-034 The bench SHALL cover: reset after the 3rd output of a group -> out_valid=0 immediately, in_ready=1; the next sample starts at (1024,0).
REQ-035 The bench SHALL cover: FM_MOD_PREEMPH_EN, MOD_GAIN=1024, in_audio=1024 twice after reset -> inc 2048 then 1024.
